// File: rtl/fetch_queue_pkg.sv
// Shared types and defaults for the fetch queue: packet layout, default sizing, count/pointer widths.
package fetch_queue_pkg;

  localparam int unsigned FQ_DEFAULT_DEPTH      = 32;
  localparam int unsigned FQ_DEFAULT_PUSH_WIDTH = 4;
  localparam int unsigned FQ_DEFAULT_POP_WIDTH  = 3;

  localparam int unsigned FQ_PTR_W = $clog2(FQ_DEFAULT_DEPTH);
  localparam int unsigned FQ_CNT_W = $clog2(FQ_DEFAULT_DEPTH + 1);

  typedef logic [FQ_PTR_W-1:0] fq_ptr_t;
  typedef logic [FQ_CNT_W-1:0] fq_count_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_packet_t;

  function automatic int unsigned fq_min(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fetch_queue_window.sv
// Combinational dispatch window: next POP_WIDTH packets starting at head.
// With FETCH_QUEUE_BYPASS_EN, same-cycle accepted pushes extend the window past the stored entries.
module fetch_queue_window
  import fetch_queue_pkg::*;
#(
  parameter int unsigned    DEPTH      = FQ_DEFAULT_DEPTH,
  parameter int unsigned    PUSH_WIDTH = FQ_DEFAULT_PUSH_WIDTH,
  parameter int unsigned    POP_WIDTH  = FQ_DEFAULT_POP_WIDTH,
  localparam int unsigned   PTR_W      = $clog2(DEPTH),
  localparam int unsigned   CNT_W      = $clog2(DEPTH + 1),
  localparam int unsigned   POP_W      = $clog2(POP_WIDTH + 1),
  localparam int unsigned   WIDX_W     = (POP_WIDTH > 1) ? $clog2(POP_WIDTH) : 1
) (
  input  logic                          flush_i,
  input  logic [PTR_W-1:0]              head_i,
  input  logic [CNT_W-1:0]              count_i,
  input  fetch_packet_t                 mem_i [DEPTH],
`ifdef FETCH_QUEUE_BYPASS_EN
  input  logic [$clog2(PUSH_WIDTH+1)-1:0] pushes_acc_i,
  input  fetch_packet_t [PUSH_WIDTH-1:0]  push_entries_i,
`endif
  output fetch_packet_t [POP_WIDTH-1:0] window_entries_o,
  output logic [POP_W-1:0]              window_valid_count_o
);

  // Sizing rules checked at elaboration.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_pow2
    $error("fetch_queue: DEPTH must be a power of two");
  end
  if (DEPTH < PUSH_WIDTH + POP_WIDTH) begin : g_depth_min
    $error("fetch_queue: DEPTH must be at least PUSH_WIDTH + POP_WIDTH");
  end
  if ((PUSH_WIDTH == 0) || (POP_WIDTH == 0)) begin : g_width_min
    $error("fetch_queue: PUSH_WIDTH and POP_WIDTH must be non-zero");
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int unsigned PIDX_W = (PUSH_WIDTH > 1) ? $clog2(PUSH_WIDTH) : 1;
`endif

  int unsigned avail;

  always_comb begin
    window_entries_o     = '0;
    window_valid_count_o = '0;
    avail                = 32'(count_i);
`ifdef FETCH_QUEUE_BYPASS_EN
    avail                = 32'(count_i) + 32'(pushes_acc_i);
`endif
    if (!flush_i) begin
      window_valid_count_o = POP_W'(fq_min(POP_WIDTH, avail));
      for (int i = 0; i < POP_WIDTH; i++) begin
        if (32'(i) < 32'(count_i)) begin
          window_entries_o[WIDX_W'(i)] = mem_i[head_i + PTR_W'(i)];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (32'(i) < avail) begin
          window_entries_o[WIDX_W'(i)] = push_entries_i[PIDX_W'(32'(i) - 32'(count_i))];
        end
`endif
      end
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Circular fetch-to-dispatch instruction queue with all-or-nothing push, clamped pop and sticky overflow.
// Optional same-cycle empty-queue bypass enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH      = FQ_DEFAULT_DEPTH,
  parameter int unsigned PUSH_WIDTH = FQ_DEFAULT_PUSH_WIDTH,
  parameter int unsigned POP_WIDTH  = FQ_DEFAULT_POP_WIDTH
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                flush,
  input  logic [$clog2(PUSH_WIDTH+1)-1:0]     push_count,
  input  fetch_packet_t [PUSH_WIDTH-1:0]      push_entries,
  output logic [$clog2(PUSH_WIDTH+1)-1:0]     free_slots,
  input  logic [$clog2(POP_WIDTH+1)-1:0]      pop_count,
  output fetch_packet_t [POP_WIDTH-1:0]       window_entries,
  output logic [$clog2(POP_WIDTH+1)-1:0]      window_valid_count,
  output logic [$clog2(DEPTH+1)-1:0]          count,
  output logic                                overflow_err
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned PSH_W  = $clog2(PUSH_WIDTH + 1);
  localparam int unsigned POP_W  = $clog2(POP_WIDTH + 1);
  localparam int unsigned PIDX_W = (PUSH_WIDTH > 1) ? $clog2(PUSH_WIDTH) : 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  fetch_packet_t    mem_q [DEPTH];

  logic             push_ok;
  logic [PSH_W-1:0] pushes_acc;
  logic [POP_W-1:0] pops_acc;

  // Free space is judged on registered occupancy only; same-cycle pops never make room.
  always_comb begin
    free_slots = PSH_W'(fq_min(PUSH_WIDTH, DEPTH - 32'(count_q)));
    push_ok    = (push_count != '0) && (push_count <= free_slots);
    pushes_acc = (push_ok && !flush) ? push_count : '0;
    pops_acc   = flush ? '0
               : ((pop_count < window_valid_count) ? pop_count : window_valid_count);
  end

  always_comb begin
    head_d     = head_q + PTR_W'(pops_acc);
    tail_d     = tail_q + PTR_W'(pushes_acc);
    count_d    = count_q + CNT_W'(pushes_acc) - CNT_W'(pops_acc);
    overflow_d = overflow_q | (!flush && (push_count != '0) && !push_ok);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Accepted packets land contiguously from tail, wrapping modulo DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PUSH_WIDTH; i++) begin
        if (PSH_W'(i) < pushes_acc) begin
          mem_q[tail_q + PTR_W'(i)] <= push_entries[PIDX_W'(i)];
        end
      end
    end
  end

  fetch_queue_window #(
    .DEPTH      (DEPTH),
    .PUSH_WIDTH (PUSH_WIDTH),
    .POP_WIDTH  (POP_WIDTH)
  ) u_window (
    .flush_i              (flush),
    .head_i               (head_q),
    .count_i              (count_q),
    .mem_i                (mem_q),
`ifdef FETCH_QUEUE_BYPASS_EN
    .pushes_acc_i         (pushes_acc),
    .push_entries_i       (push_entries),
`endif
    .window_entries_o     (window_entries),
    .window_valid_count_o (window_valid_count)
  );

  assign count        = count_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue; bypass expectations follow FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic                           clock;
  logic                           reset;
  logic                           flush;
  logic [2:0]                     push_count;
  fetch_packet_t [3:0]            push_entries;
  logic [2:0]                     free_slots;
  logic [1:0]                     pop_count;
  fetch_packet_t [2:0]            window_entries;
  logic [1:0]                     window_valid_count;
  fq_count_t                      count;
  logic                           overflow_err;

  int n_assert;
  int n_fail;

  fetch_queue #(
    .DEPTH      (FQ_DEFAULT_DEPTH),
    .PUSH_WIDTH (FQ_DEFAULT_PUSH_WIDTH),
    .POP_WIDTH  (FQ_DEFAULT_POP_WIDTH)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .flush              (flush),
    .push_count         (push_count),
    .push_entries       (push_entries),
    .free_slots         (free_slots),
    .pop_count          (pop_count),
    .window_entries     (window_entries),
    .window_valid_count (window_valid_count),
    .count              (count),
    .overflow_err       (overflow_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic fetch_packet_t pkt(input int n);
    fetch_packet_t p;
    p.pc   = 32'h0000_1000 + 32'(n * 4);
    p.inst = 32'hC0DE_0000 + 32'(n);
    return p;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pkt(input string tag, input fetch_packet_t obs, input fetch_packet_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Window holds nvalid consecutive packets starting at pkt(base); remaining slots zero.
  task automatic chk_win(input string tag, input int nvalid, input int base);
    chk({tag, "_wvc"}, int'(window_valid_count), nvalid);
    chk_pkt({tag, "_w0"}, window_entries[0], (nvalid > 0) ? pkt(base)     : '0);
    chk_pkt({tag, "_w1"}, window_entries[1], (nvalid > 1) ? pkt(base + 1) : '0);
    chk_pkt({tag, "_w2"}, window_entries[2], (nvalid > 2) ? pkt(base + 2) : '0);
  endtask

  task automatic drive(input int pc, input int pops, input int base, input logic fl);
    push_count      = 3'(pc);
    pop_count       = 2'(pops);
    flush           = fl;
    push_entries[0] = (pc > 0) ? pkt(base)     : '0;
    push_entries[1] = (pc > 1) ? pkt(base + 1) : '0;
    push_entries[2] = (pc > 2) ? pkt(base + 2) : '0;
    push_entries[3] = (pc > 3) ? pkt(base + 3) : '0;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive(0, 0, 0, 1'b0);
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_ovf", int'(overflow_err), 0);
    chk("rst_free", int'(free_slots), 4);
    chk_win("rst", 0, 0);

    // Push A..D: not visible until the next edge.
    drive(4, 0, 0, 1'b0);
    #1;
`ifndef FETCH_QUEUE_BYPASS_EN
    chk("push_lat_wvc", int'(window_valid_count), 0);
`endif
    cyc();
    chk("push4_count", int'(count), 4);
    chk("push4_free", int'(free_slots), 4);
    chk_win("push4", 3, 0);

    drive(0, 3, 0, 1'b0);
    cyc();
    chk("pop3_count", int'(count), 1);
    chk_win("pop3", 1, 3);

    drive(1, 0, 4, 1'b0);
    cyc();
    chk("push1_count", int'(count), 2);
    chk_win("push1", 2, 3);

    // Pop of 3 with only 2 valid is clamped.
    drive(0, 3, 0, 1'b0);
    #1;
    chk("clamp_pre_wvc", int'(window_valid_count), 2);
    cyc();
    chk("clamp_count", int'(count), 0);
    chk("clamp_free", int'(free_slots), 4);
    chk_win("clamp", 0, 0);

    // Fill to 30 starting at head=tail=5.
    for (int k = 0; k < 7; k++) begin
      drive(4, 0, 100 + 4 * k, 1'b0);
      cyc();
    end
    drive(2, 0, 128, 1'b0);
    cyc();
    chk("fill30_count", int'(count), 30);
    chk("fill30_free", int'(free_slots), 2);
    chk_win("fill30", 3, 100);

    // Push of 4 with only 2 free is rejected whole.
    drive(4, 0, 200, 1'b0);
    #1;
    chk("rej_pre_free", int'(free_slots), 2);
    cyc();
    chk("rej_count", int'(count), 30);
    chk("rej_ovf", int'(overflow_err), 1);
    chk_win("rej", 3, 100);

    drive(2, 0, 130, 1'b0);
    cyc();
    chk("full_count", int'(count), 32);
    chk("full_free", int'(free_slots), 0);

    // Push and pop at full: push judged on pre-pop space, so only the pop lands.
    drive(1, 3, 300, 1'b0);
    #1;
    chk("fullpp_pre_free", int'(free_slots), 0);
    cyc();
    chk("fullpp_count", int'(count), 29);
    chk("fullpp_ovf", int'(overflow_err), 1);
    chk_win("fullpp", 3, 103);

    // Flush with push and pop asserted.
    drive(4, 2, 400, 1'b1);
    #1;
    chk_win("flush_cyc", 0, 0);
    cyc();
    drive(0, 0, 0, 1'b0);
    #1;
    chk("flush_count", int'(count), 0);
    chk("flush_ovf", int'(overflow_err), 1);
    chk("flush_free", int'(free_slots), 4);
    chk_win("flush_after", 0, 0);

    // Move head/tail to 30 with an empty queue.
    for (int k = 0; k < 7; k++) begin
      drive(4, 0, 500 + 4 * k, 1'b0);
      cyc();
    end
    drive(2, 0, 528, 1'b0);
    cyc();
    chk("wfill_count", int'(count), 30);
    chk_win("wfill", 3, 500);
    for (int k = 0; k < 10; k++) begin
      drive(0, 3, 0, 1'b0);
      cyc();
    end
    chk("wdrain_count", int'(count), 0);
    chk_win("wdrain", 0, 0);

    // Push straddling 31 -> 0.
    drive(4, 0, 600, 1'b0);
    cyc();
    chk("wrap_count", int'(count), 4);
    chk_win("wrap", 3, 600);
    drive(0, 3, 0, 1'b0);
    cyc();
    chk("wrap_pop_count", int'(count), 1);
    chk_win("wrap_pop", 1, 603);
    // Next push must start at tail=2, right after pkt603 at index 1.
    drive(4, 0, 610, 1'b0);
    cyc();
    chk("wrap_tail_count", int'(count), 5);
    chk("wrap_tail_wvc", int'(window_valid_count), 3);
    chk_pkt("wrap_tail_w0", window_entries[0], pkt(603));
    chk_pkt("wrap_tail_w1", window_entries[1], pkt(610));
    chk_pkt("wrap_tail_w2", window_entries[2], pkt(611));

    // Reset mid-operation discards contents and clears overflow.
    reset = 1'b1;
    drive(0, 0, 0, 1'b0);
    cyc();
    reset = 1'b0;
    #1;
    chk("mrst_count", int'(count), 0);
    chk("mrst_ovf", int'(overflow_err), 0);
    chk("mrst_free", int'(free_slots), 4);
    chk_win("mrst", 0, 0);

    // Empty queue, push A,B with pop 1 in the same cycle.
    drive(2, 1, 700, 1'b0);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk_win("byp_cyc", 2, 700);
    cyc();
    chk("byp_count", int'(count), 1);
    chk_win("byp_after", 1, 701);
`else
    chk_win("nobyp_cyc", 0, 0);
    cyc();
    chk("nobyp_count", int'(count), 2);
    chk_win("nobyp_after", 2, 700);
`endif

    drive(0, 0, 0, 1'b0);
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised successor to the front-end instruction buffer. Sits between fetch and decode/dispatch and holds up to DEPTH fetched instructions in a circular FIFO. Accepts up to PUSH_WIDTH packets and releases up to POP_WIDTH packets per cycle. Adds over the previous generation: all-or-nothing push acceptance with a sticky overflow flag, pop clamping to valid entries, an occupancy output, and optional same-cycle empty-queue bypass.

## Interface
- DEPTH, 32, entry count; power of two, ≥ PUSH_WIDTH+POP_WIDTH
- PUSH_WIDTH, 4, max pushes per cycle
- POP_WIDTH, 3, max pops per cycle
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  mispredict squash; empties queue
- push_count  in  $clog2(PUSH_WIDTH+1)  number of valid packets in push_entries[0..n-1]
- push_entries  in  FETCH_PACKET[PUSH_WIDTH]  fetch packets, oldest at index 0
- free_slots  out  $clog2(PUSH_WIDTH+1)  min(PUSH_WIDTH, DEPTH−count)
- pop_count  in  $clog2(POP_WIDTH+1)  packets consumed by dispatch this cycle
- window_entries  out  FETCH_PACKET[POP_WIDTH]  next POP_WIDTH packets, oldest at 0; invalid slots '0
- window_valid_count  out  $clog2(POP_WIDTH+1)  valid slots in window
- count  out  $clog2(DEPTH+1)  registered occupancy
- overflow_err  out  1  sticky: a push was rejected

## Operation
- State: head, tail ($clog2(DEPTH) bits), count, overflow_err, and the storage array. Pointer wrap is natural modulo DEPTH.
- free_slots is derived from registered count only. Same-cycle pops do not add free space.
- Push accept: push_count ≠ 0 and push_count ≤ free_slots.
  - Accepted: entries 0..push_count−1 are written at tail+i and tail advances by push_count.
  - Rejected: nothing is written, tail holds, and overflow_err is set.
- Pop accept: pops_acc = min(pop_count, window_valid_count). head advances by pops_acc. A clamped excess is silently ignored.
- count_next = count + pushes_acc − pops_acc. It never exceeds DEPTH and never underflows.
- Window (without bypass): slot i is valid iff i < count and shows storage[head+i]. window_valid_count = min(POP_WIDTH, count).
- Flush:
  - head, tail and count go to 0.
  - Pushes and pops in the flush cycle are ignored.
  - window_valid_count is forced to 0 during the flush cycle.
  - overflow_err is not cleared by flush.
- Simultaneous push and pop at full occupancy: the push is still judged against pre-pop free_slots, which is conservative by design.

## Timing
- Reset: head=tail=count=0, overflow_err=0, storage cleared. After reset: free_slots=min(PUSH_WIDTH,DEPTH), window_valid_count=0, window_entries='0.
- Reset has priority over flush. Reset mid-operation discards all contents.
- Push-to-window latency is 1 cycle (0 with bypass).
- Pop takes effect at the next edge. window_entries is combinational from registered state (plus push inputs with bypass).
- Wrap-around: a push straddling index DEPTH−1→0 writes contiguous entries modulo DEPTH. The window reads across the wrap the same way.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - Window slot i with count ≤ i < count+pushes_acc shows push_entries[i−count] in the same cycle.
  - window_valid_count = min(POP_WIDTH, count+pushes_acc).
  - Bypassed packets may be popped that cycle. Storage still writes them and head advances past them, so state stays consistent.
  - Flush still zeroes the window.
- Undefined: the window shows only registered entries, and there is no combinational path from push inputs to the window.

## Structure
- FETCH_PACKET stays in sys_defs.svh.
- Add a shared package constant FQ_DEFAULT_DEPTH, plus a localparam-derived width typedef for count/pointers.
- One sub-module, fetch_queue_window: a combinational read mux producing window_entries and window_valid_count from head, count and (with bypass) the push inputs.
- Add elaboration-time assertions on the DEPTH power-of-two and minimum-size rules.

## Test plan
- Reset, then push_count=4 with packets A–D → next cycle count=4, window=A,B,C, window_valid_count=3, free_slots=4.
- Fill to count=30, then push_count=4 → rejected; count stays 30, overflow_err=1 and stays 1 after flush.
- count=2, pop_count=3 → pops_acc=2, count=0, window_valid_count=0 next cycle.
- Wrap: head=30, count=0 (tail=30), push 4 → entries land at 30,31,0,1. Window reads them in order and tail=2.
- Flush with push_count=4 and pop_count=2 asserted → window_valid_count=0 that cycle. Next cycle count=0, head=tail=0 and the pushed packets are absent.
- With FETCH_QUEUE_BYPASS_EN, empty queue, push A,B and pop_count=1 in the same cycle → window shows A,B that cycle. Next cycle count=1 and window[0]=B.
